// File: rtl/push_pull_seq_pkg.sv
// Shared register codes, mask-bit positions and FSM states for the 6809 stack sequencer.
// No logic beyond a small bit-index to register-code lookup.
package push_pull_seq_pkg;

    localparam logic [3:0] RN_D  = 4'd0;
    localparam logic [3:0] RN_X  = 4'd1;
    localparam logic [3:0] RN_Y  = 4'd2;
    localparam logic [3:0] RN_U  = 4'd3;
    localparam logic [3:0] RN_S  = 4'd4;
    localparam logic [3:0] RN_PC = 4'd5;
    localparam logic [3:0] RN_A  = 4'd8;
    localparam logic [3:0] RN_B  = 4'd9;
    localparam logic [3:0] RN_CC = 4'd10;
    localparam logic [3:0] RN_DP = 4'd11;

    localparam int PP_CC = 0;
    localparam int PP_A  = 1;
    localparam int PP_B  = 2;
    localparam int PP_DP = 3;
    localparam int PP_X  = 4;
    localparam int PP_Y  = 5;
    localparam int PP_US = 6;
    localparam int PP_PC = 7;

    typedef enum logic [1:0] {
        PPS_IDLE   = 2'd0,
        PPS_XFER   = 2'd1,
        PPS_FINISH = 2'd2
    } pps_state_t;

    // Bit 6 names the "other" stack: U when pushing/pulling S, S when on U.
    function automatic logic [3:0] pp_rn(input logic [2:0] idx, input logic use_s);
        logic [3:0] rn;
        case (idx)
            3'd7:    rn = RN_PC;
            3'd6:    rn = use_s ? RN_U : RN_S;
            3'd5:    rn = RN_Y;
            3'd4:    rn = RN_X;
            3'd3:    rn = RN_DP;
            3'd2:    rn = RN_B;
            3'd1:    rn = RN_A;
            default: rn = RN_CC;
        endcase
        return rn;
    endfunction

endpackage

// File: rtl/push_pull_seq_if.sv
// Byte-wide memory request bus driven by the stack sequencer.
// mem_ack completes a byte in the cycle it is seen; request fields hold until then.
interface push_pull_seq_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ack);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_rdata, mem_ack);
endinterface

// File: rtl/push_pull_seq_pick.sv
// Priority encoder over the remaining mask: highest bit for push, lowest for pull.
// Purely combinational; no backpressure.
module pp_pick
    import push_pull_seq_pkg::*;
(
    input  logic [7:0] mask,
    input  logic       pull,
    input  logic       use_s,
    output logic [2:0] idx,
    output logic [3:0] rn,
    output logic       wide
);

    always_comb begin
        idx = 3'd0;
        if (pull) begin
            for (int i = 7; i >= 0; i--) begin
                if (mask[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (mask[i]) idx = 3'(i);
            end
        end
        rn   = pp_rn(idx, use_s);
        wide = idx[2];
    end

endmodule

// File: rtl/push_pull_seq.sv
// 6809 PSHS/PSHU/PULS/PULU sequencer: one byte per acked cycle, done one cycle after the last ack.
// Stalls on mem_ack low with the request held; start is ignored while busy.
module push_pull_seq
    import push_pull_seq_pkg::*;
(
    input  logic                  cpu_clk,
    input  logic                  cpu_reset,
    input  logic                  start,
    input  logic                  is_pull,
    input  logic                  use_s,
    input  logic [7:0]            regmask,
    input  logic [15:0]           sp_in,
    output logic [3:0]            reg_sel,
    input  logic [15:0]           reg_rdata,
    output logic                  reg_we,
    output logic [3:0]            reg_waddr,
    output logic [15:0]           reg_wdata,
    push_pull_seq_if.master       bus,
    output logic                  sp_we,
    output logic [15:0]           sp_wdata,
    output logic                  busy,
    output logic                  done
);

    pps_state_t  state, next_state;
    logic [15:0] ptr;
    logic [7:0]  mask;
    logic        pull_q;
    logic        use_s_q;
    logic        phase;
    logic [7:0]  hi_q;

    logic [2:0]  pk_idx;
    logic [3:0]  pk_rn;
    logic        pk_wide;
    logic        ack;
    logic        last_byte;
    logic [7:0]  mask_nxt;

    pp_pick u_pick (
        .mask  (mask),
        .pull  (pull_q),
        .use_s (use_s_q),
        .idx   (pk_idx),
        .rn    (pk_rn),
        .wide  (pk_wide)
    );

    assign ack       = (state == PPS_XFER) && bus.mem_ack;
    assign last_byte = !pk_wide || phase;
    assign mask_nxt  = mask & ~(8'b1 << pk_idx);

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) state <= PPS_IDLE;
        else           state <= next_state;
    end

    always_comb begin
        next_state    = state;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 16'h0000;
        bus.mem_wdata = 8'h00;
        reg_sel       = 4'd0;
        sp_we         = 1'b0;
        sp_wdata      = 16'h0000;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            PPS_IDLE: begin
                if (start) next_state = (regmask != 8'h00) ? PPS_XFER : PPS_FINISH;
            end
            PPS_XFER: begin
                busy         = 1'b1;
                bus.mem_req  = 1'b1;
                bus.mem_we   = !pull_q;
                bus.mem_addr = pull_q ? ptr : ptr - 16'd1;
                if (!pull_q) begin
                    reg_sel       = pk_rn;
                    // 16-bit pushes go low byte first, high byte second
                    bus.mem_wdata = (pk_wide && phase) ? reg_rdata[15:8] : reg_rdata[7:0];
                end
                if (bus.mem_ack && last_byte && (mask_nxt == 8'h00)) next_state = PPS_FINISH;
            end
            PPS_FINISH: begin
                busy       = 1'b1;
                done       = 1'b1;
                sp_we      = 1'b1;
                sp_wdata   = ptr;
                next_state = PPS_IDLE;
            end
            default: next_state = PPS_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            ptr       <= 16'h0000;
            mask      <= 8'h00;
            pull_q    <= 1'b0;
            use_s_q   <= 1'b0;
            phase     <= 1'b0;
            hi_q      <= 8'h00;
            reg_we    <= 1'b0;
            reg_waddr <= 4'd0;
            reg_wdata <= 16'h0000;
        end else begin
            reg_we    <= 1'b0;
            reg_waddr <= 4'd0;
            reg_wdata <= 16'h0000;
            if (state == PPS_IDLE && start) begin
                ptr     <= sp_in;
                mask    <= regmask;
                pull_q  <= is_pull;
                use_s_q <= use_s;
                phase   <= 1'b0;
            end else if (ack) begin
                ptr <= pull_q ? ptr + 16'd1 : ptr - 16'd1;
                if (last_byte) begin
                    mask  <= mask_nxt;
                    phase <= 1'b0;
                end else begin
                    phase <= 1'b1;
                end
                // Pulled 16-bit values arrive high byte first
                if (pull_q) begin
                    if (!last_byte) hi_q <= bus.mem_rdata;
                    if (last_byte) begin
                        reg_we    <= 1'b1;
                        reg_waddr <= pk_rn;
                        reg_wdata <= pk_wide ? {hi_q, bus.mem_rdata} : {8'h00, bus.mem_rdata};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_push_pull_seq.sv
// Directed bench for push_pull_seq: memory/register-file models, logged transfers checked against hand values.
module tb_push_pull_seq;
    import push_pull_seq_pkg::*;

    logic        cpu_clk   = 1'b0;
    logic        cpu_reset = 1'b1;
    logic        start     = 1'b0;
    logic        is_pull   = 1'b0;
    logic        use_s     = 1'b1;
    logic [7:0]  regmask   = 8'h00;
    logic [15:0] sp_in     = 16'h0000;
    logic [3:0]  reg_sel;
    logic [15:0] reg_rdata;
    logic        reg_we;
    logic [3:0]  reg_waddr;
    logic [15:0] reg_wdata;
    logic        sp_we;
    logic [15:0] sp_wdata;
    logic        busy;
    logic        done;

    push_pull_seq_if mbus();

    logic [7:0]  mem [65536];
    logic [15:0] rf  [16];
    int waits = 0;
    int wcnt  = 0;
    int cyc   = 0;
    int n_chk = 0;
    int n_fail = 0;

    logic [23:0] wr_q[$];
    logic [3:0]  rw_a_q[$];
    logic [15:0] rw_d_q[$];
    int          rw_c_q[$];
    int          req_cnt, ack_cnt, done_cnt, spwe_cnt, t_done;
    logic [15:0] sp_last;

    push_pull_seq dut (
        .cpu_clk   (cpu_clk),
        .cpu_reset (cpu_reset),
        .start     (start),
        .is_pull   (is_pull),
        .use_s     (use_s),
        .regmask   (regmask),
        .sp_in     (sp_in),
        .reg_sel   (reg_sel),
        .reg_rdata (reg_rdata),
        .reg_we    (reg_we),
        .reg_waddr (reg_waddr),
        .reg_wdata (reg_wdata),
        .bus       (mbus),
        .sp_we     (sp_we),
        .sp_wdata  (sp_wdata),
        .busy      (busy),
        .done      (done)
    );

    assign reg_rdata      = rf[reg_sel];
    assign mbus.mem_ack   = mbus.mem_req && (wcnt >= waits);
    assign mbus.mem_rdata = mem[mbus.mem_addr];

    always #5 cpu_clk = ~cpu_clk;

    always @(posedge cpu_clk) begin
        cyc  <= cyc + 1;
        wcnt <= (mbus.mem_req && !mbus.mem_ack) ? wcnt + 1 : 0;
    end

    always @(negedge cpu_clk) begin
        if (mbus.mem_req) req_cnt++;
        if (mbus.mem_req && mbus.mem_ack) begin
            ack_cnt++;
            if (mbus.mem_we) begin
                wr_q.push_back({mbus.mem_addr, mbus.mem_wdata});
                mem[mbus.mem_addr] = mbus.mem_wdata;
            end
        end
        if (reg_we) begin
            rw_a_q.push_back(reg_waddr);
            rw_d_q.push_back(reg_wdata);
            rw_c_q.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            t_done = cyc;
        end
        if (sp_we) begin
            spwe_cnt++;
            sp_last = sp_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_q.delete();
        rw_a_q.delete();
        rw_d_q.delete();
        rw_c_q.delete();
        req_cnt  = 0;
        ack_cnt  = 0;
        done_cnt = 0;
        spwe_cnt = 0;
        t_done   = -1000;
        sp_last  = 16'h0000;
    endtask

    task automatic run_op(input logic pull, input logic us, input logic [7:0] m,
                          input logic [15:0] sp, input int w, input bit restart, output int lat);
        int t0;
        clear_log();
        waits = w;
        @(posedge cpu_clk); #1;
        start = 1'b1; is_pull = pull; use_s = us; regmask = m; sp_in = sp;
        t0 = cyc;
        @(posedge cpu_clk); #1;
        start = 1'b0;
        if (restart) begin
            @(posedge cpu_clk); #1;
            start = 1'b1; regmask = 8'h01;
            @(posedge cpu_clk); #1;
            start = 1'b0;
        end
        for (int i = 0; i < 300 && done_cnt == 0; i++) @(posedge cpu_clk);
        repeat (3) @(posedge cpu_clk);
        check("done_count", done_cnt, 1);
        lat = t_done - t0;
    endtask

    task automatic check_wr(input string tag, input int i, input logic [15:0] a, input logic [7:0] d);
        logic [23:0] got;
        got = (i < wr_q.size()) ? wr_q[i] : 24'hxxxxxx;
        check(tag, got, {a, d});
    endtask

    task automatic check_rw(input string tag, input int i, input logic [3:0] a, input logic [15:0] d);
        logic [19:0] got;
        got = (i < rw_a_q.size()) ? {rw_a_q[i], rw_d_q[i]} : 20'hxxxxx;
        check(tag, got, {a, d});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [3:0]  ea [8];
        logic [15:0] ed [8];
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
        rf[RN_PC] = 16'h1234;
        rf[RN_A]  = 16'h0056;
        rf[RN_B]  = 16'h009A;
        rf[RN_S]  = 16'hBEEF;
        for (int i = 0; i < 12; i++) mem[16'h2000 + i] = 8'h11 * 8'(i + 1);
        clear_log();

        #12;
        check("reset_outputs",
              {busy, done, sp_we, reg_we, mbus.mem_req, mbus.mem_we},
              6'b000000);
        check("reset_buses", {mbus.mem_addr, sp_wdata, reg_wdata}, 48'h0);
        @(posedge cpu_clk); #1;
        cpu_reset = 1'b0;

        // PSHS: mask 0x86 selects PC, B and A, pushed in that order
        run_op(1'b0, 1'b1, 8'h86, 16'h1000, 0, 1'b0, lat);
        check("pshs_nwr", wr_q.size(), 4);
        check_wr("pshs_wr0", 0, 16'h0FFF, 8'h34);
        check_wr("pshs_wr1", 1, 16'h0FFE, 8'h12);
        check_wr("pshs_wr2", 2, 16'h0FFD, 8'h9A);
        check_wr("pshs_wr3", 3, 16'h0FFC, 8'h56);
        check("pshs_sp", sp_last, 16'h0FFC);
        check("pshs_lat", lat, 5);
        check("pshs_no_regwe", rw_a_q.size(), 0);

        run_op(1'b1, 1'b1, 8'h86, 16'h0FFC, 0, 1'b0, lat);
        check("puls_nrw", rw_a_q.size(), 3);
        check_rw("puls_rw0", 0, RN_A, 16'h0056);
        check_rw("puls_rw1", 1, RN_B, 16'h009A);
        check_rw("puls_rw2", 2, RN_PC, 16'h1234);
        check("puls_sp", sp_last, 16'h1000);
        check("puls_lat", lat, 5);
        check("puls_last_we_at_done", (rw_c_q.size() == 3) ? rw_c_q[2] : -1, t_done);

        run_op(1'b0, 1'b1, 8'h00, 16'h4321, 0, 1'b0, lat);
        check("mask0_req", req_cnt, 0);
        check("mask0_lat", lat, 1);
        check("mask0_sp", sp_last, 16'h4321);
        check("mask0_spwe", spwe_cnt, 1);

        run_op(1'b0, 1'b0, 8'h40, 16'h0001, 0, 1'b0, lat);
        check("pshu_nwr", wr_q.size(), 2);
        check_wr("pshu_wr0", 0, 16'h0000, 8'hEF);
        check_wr("pshu_wr1", 1, 16'hFFFF, 8'hBE);
        check("pshu_sp", sp_last, 16'hFFFF);
        check("pshu_lat", lat, 3);

        // Full pull with two wait cycles per byte and a stray start while busy
        ea = '{RN_CC, RN_A, RN_B, RN_DP, RN_X, RN_Y, RN_U, RN_PC};
        ed = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h5566, 16'h7788, 16'h99AA, 16'hBBCC};
        run_op(1'b1, 1'b1, 8'hFF, 16'h2000, 2, 1'b1, lat);
        check("full_acks", ack_cnt, 12);
        check("full_lat", lat, 37);
        check("full_sp", sp_last, 16'h200C);
        check("full_nrw", rw_a_q.size(), 8);
        for (int i = 0; i < 8; i++) check_rw($sformatf("full_rw%0d", i), i, ea[i], ed[i]);

        clear_log();
        waits = 0;
        @(posedge cpu_clk); #1;
        start = 1'b1; is_pull = 1'b1; use_s = 1'b1; regmask = 8'h10; sp_in = 16'h2004;
        @(posedge cpu_clk); #1;
        start = 1'b0;
        @(posedge cpu_clk); #1;
        check("rst_byte2_addr", mbus.mem_addr, 16'h2005);
        cpu_reset = 1'b1;
        #1;
        check("rst_outputs", {busy, done, sp_we, reg_we, mbus.mem_req, mbus.mem_we}, 6'b000000);
        check("rst_buses", {mbus.mem_addr, sp_wdata, reg_wdata, reg_sel}, 52'h0);
        @(posedge cpu_clk); #1;
        cpu_reset = 1'b0;
        repeat (3) @(posedge cpu_clk);
        check("rst_no_regwe", rw_a_q.size(), 0);
        check("rst_no_spwe", spwe_cnt, 0);

        run_op(1'b1, 1'b1, 8'h02, 16'h2001, 0, 1'b0, lat);
        check_rw("after_rst_rw", 0, RN_A, 16'h0022);
        check("after_rst_sp", sp_last, 16'h2002);
        check("after_rst_lat", lat, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
